// File: rtl/core_seq_pkg.sv
// -----------------------------------------------------------------------------
// core_seq_pkg
// Shared types for the core sequencer: state encoding localparams, the state
// enum built from them, and a helper that identifies the handshake-wait
// states (the states a stall watchdog cares about).
// -----------------------------------------------------------------------------
package core_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_IWAIT = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_MWAIT = 3'd5;
    localparam logic [2:0] ST_WB    = 3'd6;
    localparam logic [2:0] ST_HALT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        IWAIT = ST_IWAIT,
        EXEC  = ST_EXEC,
        MEM   = ST_MEM,
        MWAIT = ST_MWAIT,
        WB    = ST_WB,
        HALT  = ST_HALT
    } state_t;

    // States that sit waiting on an external handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == IWAIT) || (s == MEM) || (s == MWAIT);
    endfunction

endpackage

// File: rtl/core_seq_tmo.sv
// -----------------------------------------------------------------------------
// core_seq_tmo
// Stall watchdog. Counts consecutive cycles spent in a wait state without the
// awaited handshake and flags expiry on the (2^TMO_W-1)-th such cycle, so the
// sequencer can leave the stuck state on that same clock edge.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-low reset
//   run      sequencer is in a handshake-wait state
//   kick     the awaited handshake occurs this cycle (state will change)
//   expired  combinational: this is the (2^TMO_W-1)-th consecutive stalled cycle
// -----------------------------------------------------------------------------
module core_seq_tmo #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    // cnt holds the number of stalled cycles already completed, so the current
    // cycle is stall number cnt+1; expiry is when that reaches 2^TMO_W-1.
    localparam logic [TMO_W-1:0] LAST = TMO_W'((2 ** TMO_W) - 2);

    logic [TMO_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || kick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && !kick && (cnt == LAST);

endmodule

// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq
// Multi-cycle instruction sequencer: fetches an instruction at pc, holds it
// for the external decoder, optionally performs one load/store transaction,
// then commits (GPR/CSR write strobes, pc <= dec_next_pc) and either refetches
// or halts on ebreak.
//
// Build option:
//   CORE_SEQ_TIMEOUT_EN  when defined, a stall watchdog (core_seq_tmo) sends
//                        the sequencer to HALT with bus_err set after
//                        2^TMO_W-1 consecutive stalled cycles in a wait state.
//                        When undefined, waits are unbounded and bus_err is 0.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr    fetch request (ifu_addr = pc)
//   ifu_resp_valid, ifu_resp_data    fetch response
//   lsu_req_valid/ready              load/store request
//   lsu_resp_valid, lsu_resp_data    load/store response
//   dec_mem_rd/wr, dec_gpr_wr,
//   dec_csr_wr, dec_ebreak           decoded controls for the held instruction
//   dec_next_pc                      next pc from branch logic
//   pc, inst, ld_data                architectural pc, held instruction, load data
//   gpr_wr_en, csr_wr_en             one-cycle commit strobes (WB only)
//   halted, bus_err                  sticky status
// -----------------------------------------------------------------------------
module core_seq
    import core_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int              TMO_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_addr,
    input  logic            ifu_resp_valid,
    input  logic [31:0]     ifu_resp_data,
    output logic            lsu_req_valid,
    input  logic            lsu_req_ready,
    input  logic            lsu_resp_valid,
    input  logic [XLEN-1:0] lsu_resp_data,
    input  logic            dec_mem_rd,
    input  logic            dec_mem_wr,
    input  logic            dec_gpr_wr,
    input  logic            dec_csr_wr,
    input  logic            dec_ebreak,
    input  logic [XLEN-1:0] dec_next_pc,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] ld_data,
    output logic            gpr_wr_en,
    output logic            csr_wr_en,
    output logic            halted,
    output logic            bus_err
);

    if (TMO_W < 2) begin : g_bad_tmo_w
        $error("core_seq: TMO_W must be at least 2");
    end

    state_t state;
    state_t next_state;

`ifdef CORE_SEQ_TIMEOUT_EN
    logic tmo_run;
    logic tmo_kick;
    logic tmo_expired;

    assign tmo_run  = is_wait_state(state);
    // Built from the handshake inputs rather than next_state, which itself
    // depends on tmo_expired.
    assign tmo_kick = ((state == FETCH) && ifu_req_ready)  ||
                      ((state == IWAIT) && ifu_resp_valid) ||
                      ((state == MEM)   && lsu_req_ready)  ||
                      ((state == MWAIT) && lsu_resp_valid);

    core_seq_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .run     (tmo_run),
        .kick    (tmo_kick),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (tmo_expired) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        next_state    = state;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        gpr_wr_en     = 1'b0;
        csr_wr_en     = 1'b0;
        halted        = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) next_state = IWAIT;
            end
            IWAIT: begin
                if (ifu_resp_valid) next_state = EXEC;
            end
            EXEC: next_state = (dec_mem_rd || dec_mem_wr) ? MEM : WB;
            MEM: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) next_state = MWAIT;
            end
            MWAIT: begin
                if (lsu_resp_valid) next_state = WB;
            end
            WB: begin
                gpr_wr_en  = dec_gpr_wr;
                csr_wr_en  = dec_csr_wr;
                next_state = dec_ebreak ? HALT : FETCH;
            end
            HALT: halted = 1'b1;
            default: next_state = IDLE;
        endcase
`ifdef CORE_SEQ_TIMEOUT_EN
        if (tmo_expired) next_state = HALT;
`endif
    end

    // pc drives the fetch address directly, so it is stable for the whole
    // FETCH stall by construction.
    assign ifu_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            inst    <= '0;
            ld_data <= '0;
        end else begin
            if ((state == IWAIT) && ifu_resp_valid) inst <= ifu_resp_data;
            if ((state == MWAIT) && lsu_resp_valid && dec_mem_rd) ld_data <= lsu_resp_data;
            if (state == WB) pc <= dec_next_pc;
        end
    end

endmodule
